// File: rtl/aes_key_expand.sv
// AES-128 key schedule: loads key_in on start, emits round keys 0..10 over valid/ready (AES_KEYEXP_STORE_EN adds an 11-entry round-key store).
// Latency: round 0 is valid the cycle after start; each accepted beat presents the next round key one cycle later.
// Backpressure: key_ready low holds round_key/round_idx/key_valid; key_ready has no combinational path to any output.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         start,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
`ifdef AES_KEYEXP_STORE_EN
    ,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

    state_t       state;
    logic [127:0] next_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic         beat;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        sbox = 8'h00;
        case (a)
            8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
            8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
            8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
            8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
            8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
            8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
            8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
            8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
            8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
            8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
            8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
            8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
            8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
            8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
            8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
            8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
            8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
            8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
            8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
            8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
            8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
            8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
            8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
            8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
            8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
            8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
            8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
            8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
            8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
            8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
            8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
            8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
            default: sbox = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Next round key derived from the current one; w3 is the low word of the register.
    always_comb begin
        rot_word = {round_key[23:0], round_key[31:24]};
        sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        t_word   = sub_word ^ {rcon(round_idx + 4'd1), 24'h000000};
        w0n      = round_key[127:96] ^ t_word;
        w1n      = round_key[95:64]  ^ w0n;
        w2n      = round_key[63:32]  ^ w1n;
        w3n      = round_key[31:0]   ^ w2n;
        next_key = {w0n, w1n, w2n, w3n};
    end

    assign beat = (state == EMIT) && key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_key <= 128'h0;
            round_idx <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        round_idx <= 4'd0;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (beat) begin
                        if (round_idx != 4'd10) begin
                            round_key <= next_key;
                            round_idx <= round_idx + 4'd1;
                        end else begin
                            key_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_KEYEXP_STORE_EN
    logic [127:0] store [0:10];

    // Entry k is written as soon as round key k is produced, so all 11 are present by done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                store[i] <= 128'h0;
            end
        end else if (state == IDLE && start) begin
            store[0] <= key_in;
        end else if (beat && round_idx != 4'd10) begin
            store[round_idx + 4'd1] <= next_key;
        end
    end

    assign rk_rd_data = (rk_rd_idx <= 4'd10) ? store[rk_rd_idx] : 128'h0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: word-level FIPS-197 reference model feeding a scoreboard queue checked by a monitor.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         start;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;
`ifdef AES_KEYEXP_STORE_EN
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
`endif

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .start     (start),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
`ifdef AES_KEYEXP_STORE_EN
        ,
        .rk_rd_idx (rk_rd_idx),
        .rk_rd_data(rk_rd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    logic [127:0] exp_rk [11];
    logic [127:0] seen   [11];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           exp_done = 0;
    bit           prev_hold = 0;
    logic [132:0] prev_out;

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // GF(2^8) arithmetic; the S-box is derived as multiplicative inverse plus affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    task automatic compute_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected entry per accepted beat, checks stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) check("hold_stable", {123'h0, round_key, round_idx, key_valid} >> 0,
                                 {123'h0, prev_out} >> 0);
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {124'h0, round_idx}, 128'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_idx", {124'h0, round_idx}, {124'h0, e.idx});
                    check("beat_key", round_key, e.key);
                    seen[round_idx] = round_key;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_queue_empty", 128'(exp_q.size()), 128'h0);
            end
            prev_hold = key_valid && !key_ready;
            prev_out  = {round_key, round_idx, key_valid};
        end
    end

    task automatic push_expected(input logic [127:0] k);
        compute_schedule(k);
        for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), exp_rk[r]});
        for (int r = 0; r < 11; r++) seen[r] = 128'h0;
    endtask

    task automatic run_key(input logic [127:0] k, input bit rnd_ready, input bit inject,
                           output int cyc);
        push_expected(k);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        check("busy_after_start", {127'h0, busy}, 128'h1);
        while (!done && cyc < 400) begin
            key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && cyc == 4) begin
                start  = 1'b1;
                key_in = ~k;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check("done_seen", {127'h0, done}, 128'h1);
        exp_done++;
        @(posedge clk); #1;
        check("done_one_cycle", {127'h0, done}, 128'h0);
        check("busy_clear", {127'h0, busy}, 128'h0);
        key_ready = 1'b0;
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; key_in = 128'h0;
`ifdef AES_KEYEXP_STORE_EN
        rk_rd_idx = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {round_key}, 128'h0);
        check("reset_ctrl", {124'h0, round_idx, key_valid, busy, done} >> 3 << 3 |
              {125'h0, key_valid, busy, done}, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 A.1 with key_ready held high.
        run_key(A1_KEY, 1'b0, 1'b0, cyc);
        check("a1_done_cycle", 128'(cyc), 128'd12);
        check("a1_round0", seen[0], A1_KEY);
        check("a1_round1", seen[1], A1_R1);
        check("a1_round10", seen[10], A1_R10);
`ifdef AES_KEYEXP_STORE_EN
        rk_rd_idx = 4'd10; #1;
        check("store_idx10", rk_rd_data, A1_R10);
        rk_rd_idx = 4'd11; #1;
        check("store_idx11", rk_rd_data, 128'h0);
        rk_rd_idx = 4'd0; #1;
        check("store_idx0", rk_rd_data, A1_KEY);
`endif

        // Random backpressure on the same key.
        run_key(A1_KEY, 1'b1, 1'b0, cyc);
        check("bp_round10", seen[10], A1_R10);

        // start with another key during EMIT must be ignored.
        run_key(A1_KEY, 1'b0, 1'b1, cyc);
        check("inject_round1", seen[1], A1_R1);
        check("inject_round10", seen[10], A1_R10);

        // Reset while round 5 is presented aborts without done.
        push_expected(A1_KEY);
        key_in = A1_KEY; start = 1'b1; key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (round_idx != 4'd5 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_idx5", {124'h0, round_idx}, 128'd5);
        key_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_key", round_key, 128'h0);
        check("abort_ctrl", {124'h0, round_idx, key_valid, busy, done} >> 3, 128'h0);
        check("abort_flags", {125'h0, key_valid, busy, done}, 128'h0);
        exp_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", {127'h0, done}, 128'h0);
        end
        run_key(A1_KEY, 1'b1, 1'b0, cyc);
        check("after_abort_round10", seen[10], A1_R10);

        // All-zero key.
        run_key(128'h0, 1'b0, 1'b0, cyc);
        check("zero_round1", seen[1], Z_R1);
        check("zero_round10", seen[10], Z_R10);

        // Random keys with random backpressure; model-only expectations.
        for (int n = 0; n < 6; n++) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, n[0], cyc);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'h0);
        check("done_count", 128'(done_cnt), 128'(exp_done));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
